// File: rtl/segasys1_snd_pkg.sv
// Shared definitions for the Sega System 1 sound command path (main CPU -> sound board).
package segasys1_snd_pkg;

   localparam int unsigned SndCmdW    = 8;
   localparam int unsigned DefHoldCyc = 16;
   localparam int unsigned DefGapCyc  = 64;
   localparam int unsigned DefFifoAw  = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } sndState_e;

   // A zero-length phase would merge adjacent strobes, so it is stretched to one cycle.
   function automatic int unsigned cycNorm(input int unsigned c);
      return (c == 0) ? 1 : c;
   endfunction

   function automatic int unsigned cntWidth(input int unsigned maxCyc);
      return (maxCyc > 1) ? $clog2(maxCyc) : 1;
   endfunction

endpackage

// File: rtl/segasys1_sndcmd_tx_fifo.sv
// Small synchronous command FIFO; a push while full is accepted when a pop happens in the same cycle.
module sndcmd_fifo
   import segasys1_snd_pkg::*;
#(
   parameter int unsigned AW = DefFifoAw,
   parameter int unsigned W  = SndCmdW
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int unsigned Depth = 1 << AW;

   logic [W-1:0]  mem_q [Depth];
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [AW:0]   count_q, count_d;
   logic          pushOk, popOk;

   assign popOk  = pop_i && !empty_o;
   assign pushOk = push_i && (!full_o || popOk);

   always_comb begin
      count_d = count_q;
      case ({pushOk, popOk})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (pushOk) wrPtr_q <= wrPtr_q + AW'(1);
         if (popOk)  rdPtr_q <= rdPtr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (pushOk) mem_q[wrPtr_q] <= data_i;
   end

   assign data_o  = mem_q[rdPtr_q];
   assign full_o  = (count_q == (AW+1)'(Depth));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/segasys1_sndcmd_tx.sv
// Main-side sound command transmitter: buffers CPU writes and emits one sndstart pulse per command.
// Define SNDCMD_FIFO_EN for a 2^FIFO_AW deep FIFO; otherwise a single pending register is used.
module segasys1_sndcmd_tx
   import segasys1_snd_pkg::*;
#(
   parameter int unsigned HOLD_CYC = DefHoldCyc,
   parameter int unsigned GAP_CYC  = DefGapCyc,
   parameter int unsigned FIFO_AW  = DefFifoAw
) (
   input  logic               clk8M,
   input  logic               reset_n,
   input  logic               cmd_wr,
   input  logic [SndCmdW-1:0] cmd_data,
   input  logic               ovf_clr,
   output logic [SndCmdW-1:0] sndno,
   output logic               sndstart,
   output logic               busy,
   output logic               full,
   output logic               overflow
);

   localparam int unsigned HoldEff = cycNorm(HOLD_CYC);
   localparam int unsigned GapEff  = cycNorm(GAP_CYC);
   localparam int unsigned MaxCyc  = (HoldEff > GapEff) ? HoldEff : GapEff;
   localparam int unsigned CntW    = cntWidth(MaxCyc);
   localparam logic [CntW-1:0] HoldLoad = CntW'(HoldEff - 1);
   localparam logic [CntW-1:0] GapLoad  = CntW'(GapEff - 1);

   sndState_e          state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [SndCmdW-1:0] sndno_q, sndno_d;
   logic               start_q, start_d;
   logic               overflow_q, overflow_d;

   logic               pop;
   logic               bufEmpty, bufFull;
   logic [SndCmdW-1:0] headData;

`ifdef SNDCMD_FIFO_EN
   sndcmd_fifo #(
      .AW(FIFO_AW),
      .W (SndCmdW)
   ) uFifo (
      .clk_i  (clk8M),
      .rst_ni (reset_n),
      .push_i (cmd_wr),
      .pop_i  (pop),
      .data_i (cmd_data),
      .data_o (headData),
      .full_o (bufFull),
      .empty_o(bufEmpty)
   );
`else
   localparam int unsigned unusedFifoAw = FIFO_AW;

   logic               pendValid_q, pendValid_d;
   logic [SndCmdW-1:0] pend_q, pend_d;

   // The command being played lives in sndno, so the slot frees up on the same edge it is popped.
   always_comb begin
      pendValid_d = pendValid_q;
      pend_d      = pend_q;
      if (pop) pendValid_d = 1'b0;
      if (cmd_wr && (!pendValid_q || pop)) begin
         pendValid_d = 1'b1;
         pend_d      = cmd_data;
      end
   end

   always_ff @(posedge clk8M or negedge reset_n) begin
      if (!reset_n) begin
         pendValid_q <= 1'b0;
         pend_q      <= '0;
      end else begin
         pendValid_q <= pendValid_d;
         pend_q      <= pend_d;
      end
   end

   assign headData = pend_q;
   assign bufFull  = pendValid_q;
   assign bufEmpty = !pendValid_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sndno_d = sndno_q;
      start_d = start_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!bufEmpty) begin
               pop     = 1'b1;
               sndno_d = headData;
               start_d = 1'b1;
               cnt_d   = HoldLoad;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               start_d = 1'b0;
               cnt_d   = GapLoad;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: begin
            start_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // A drop and a clear in the same cycle must leave the flag set.
   assign overflow_d = (cmd_wr && bufFull && !pop) || (overflow_q && !ovf_clr);

   always_ff @(posedge clk8M or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sndno_q    <= '0;
         start_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sndno_q    <= sndno_d;
         start_q    <= start_d;
         overflow_q <= overflow_d;
      end
   end

   assign sndno    = sndno_q;
   assign sndstart = start_q;
   assign overflow = overflow_q;
   assign full     = bufFull;
   assign busy     = (state_q != ST_IDLE) || !bufEmpty;

endmodule

// File: tb/tb_segasys1_sndcmd_tx.sv
// Scoreboard bench for segasys1_sndcmd_tx; adapts its drop scenarios to SNDCMD_FIFO_EN.
module tb_segasys1_sndcmd_tx;

   localparam int HoldCyc = 16;
   localparam int GapCyc  = 64;
   localparam int Spacing = HoldCyc + GapCyc + 1;

   logic       clk8M = 1'b0;
   logic       reset_n;
   logic       cmd_wr;
   logic [7:0] cmd_data;
   logic       ovf_clr;
   logic [7:0] sndno;
   logic       sndstart;
   logic       busy;
   logic       full;
   logic       overflow;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         riseCount = 0;
   int         lastFallCyc = 0;
   int         highLen = 0;
   logic       prevStart = 1'b0;
   logic [7:0] expQ[$];
   int         riseCyc[$];

   segasys1_sndcmd_tx #(
      .HOLD_CYC(HoldCyc),
      .GAP_CYC (GapCyc),
      .FIFO_AW (2)
   ) dut (
      .clk8M   (clk8M),
      .reset_n (reset_n),
      .cmd_wr  (cmd_wr),
      .cmd_data(cmd_data),
      .ovf_clr (ovf_clr),
      .sndno   (sndno),
      .sndstart(sndstart),
      .busy    (busy),
      .full    (full),
      .overflow(overflow)
   );

   always #5 clk8M = ~clk8M;

   initial begin
      forever begin
         @(posedge clk8M);
         cyc++;
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d, input bit accept);
      @(negedge clk8M);
      cmd_wr   = 1'b1;
      cmd_data = d;
      if (accept) expQ.push_back(d);
   endtask

   task automatic endWrites();
      @(negedge clk8M);
      cmd_wr   = 1'b0;
      cmd_data = 8'h00;
      ovf_clr  = 1'b0;
   endtask

   task automatic waitIdle(output int doneCyc);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk8M);
         if (!busy) begin
            doneCyc = cyc;
            return;
         end
      end
      checks++;
      errors++;
      doneCyc = cyc;
      $display("[TB] FAIL idle_timeout: busy still %0b, required 0 within 3000 cycles", busy);
   endtask

   // Monitor: every rising sndstart pops the scoreboard; every falling edge checks the high time.
   initial begin
      logic [7:0] expVal;
      forever begin
         @(negedge clk8M);
         if (reset_n !== 1'b1) begin
            prevStart = 1'b0;
            highLen   = 0;
         end else begin
            if (sndstart && !prevStart) begin
               riseCount++;
               riseCyc.push_back(cyc);
               highLen = 1;
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_pulse: got sndno=%0h, required no pulse", sndno);
               end else begin
                  expVal = expQ.pop_front();
                  checkOutput("pulse_sndno", int'(sndno), int'(expVal));
               end
            end else if (sndstart) begin
               highLen++;
            end else if (prevStart) begin
               checkOutput("hold_len", highLen, HoldCyc);
               lastFallCyc = cyc;
            end
            prevStart = sndstart;
         end
      end
   end

   initial begin
      int doneCyc;
      int writeCyc;
      int r0;
      int nAcc;
      logic [7:0] t2Data [3];

      reset_n  = 1'b0;
      cmd_wr   = 1'b0;
      cmd_data = 8'h00;
      ovf_clr  = 1'b0;
      repeat (3) @(negedge clk8M);
      #2 reset_n = 1'b1;
      @(negedge clk8M);
      checkOutput("rst_sndno", int'(sndno), 0);
      checkOutput("rst_sndstart", int'(sndstart), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_full", int'(full), 0);
      checkOutput("rst_overflow", int'(overflow), 0);

      $display("[TB] single write 0x25");
      riseCyc.delete();
      r0 = riseCount;
      applyStimulus(8'h25, 1'b1);
      writeCyc = cyc;
      endWrites();
      checkOutput("t1_busy_up", int'(busy), 1);
      waitIdle(doneCyc);
      checkOutput("t1_pulses", riseCount - r0, 1);
      if (riseCyc.size() > 0) checkOutput("t1_latency", riseCyc[0] - writeCyc, 2);
      checkOutput("t1_gap_to_idle", doneCyc - lastFallCyc, GapCyc);
      checkOutput("t1_sndno_kept", int'(sndno), 8'h25);
      checkOutput("t1_overflow", int'(overflow), 0);

      $display("[TB] back-to-back writes");
      t2Data = '{8'h01, 8'h02, 8'h03};
`ifdef SNDCMD_FIFO_EN
      nAcc = 3;
`else
      nAcc = 2;
`endif
      riseCyc.delete();
      r0 = riseCount;
      for (int i = 0; i < nAcc; i++) applyStimulus(t2Data[i], 1'b1);
      endWrites();
      waitIdle(doneCyc);
      checkOutput("t2_pulses", riseCount - r0, nAcc);
      for (int i = 1; i < riseCyc.size(); i++) checkOutput("t2_spacing", riseCyc[i] - riseCyc[i-1], Spacing);
      checkOutput("t2_overflow", int'(overflow), 0);

      $display("[TB] repeated value 0x10");
      riseCyc.delete();
      r0 = riseCount;
      applyStimulus(8'h10, 1'b1);
      applyStimulus(8'h10, 1'b1);
      endWrites();
      waitIdle(doneCyc);
      checkOutput("t3_edges", riseCount - r0, 2);
      if (riseCyc.size() == 2) checkOutput("t3_spacing", riseCyc[1] - riseCyc[0], Spacing);

      $display("[TB] overflow on full buffer, clear arriving with the drop");
      r0 = riseCount;
`ifdef SNDCMD_FIFO_EN
      for (int i = 0; i < 5; i++) applyStimulus(8'h31 + 8'(i), 1'b1);
      applyStimulus(8'h36, 1'b0);
      nAcc = 5;
`else
      applyStimulus(8'hA0, 1'b1);
      applyStimulus(8'hA1, 1'b1);
      applyStimulus(8'hA2, 1'b0);
      nAcc = 2;
`endif
      ovf_clr = 1'b1;
      endWrites();
      checkOutput("t4_overflow_set", int'(overflow), 1);
      checkOutput("t4_full", int'(full), 1);
      waitIdle(doneCyc);
      checkOutput("t4_pulses", riseCount - r0, nAcc);
      checkOutput("t4_overflow_sticky", int'(overflow), 1);
      checkOutput("t4_full_drained", int'(full), 0);
      @(negedge clk8M);
      ovf_clr = 1'b1;
      @(negedge clk8M);
      ovf_clr = 1'b0;
      checkOutput("t4_overflow_clr", int'(overflow), 0);

      $display("[TB] reset during HOLD with commands queued");
      applyStimulus(8'h51, 1'b1);
      applyStimulus(8'h52, 1'b1);
`ifdef SNDCMD_FIFO_EN
      applyStimulus(8'h53, 1'b1);
`endif
      endWrites();
      repeat (4) @(negedge clk8M);
      checkOutput("t5_in_hold", int'(sndstart), 1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("t5_sndstart_async", int'(sndstart), 0);
      checkOutput("t5_busy_cleared", int'(busy), 0);
      checkOutput("t5_full_cleared", int'(full), 0);
      checkOutput("t5_sndno_cleared", int'(sndno), 0);
      expQ.delete();
      @(negedge clk8M);
      #2 reset_n = 1'b1;
      r0 = riseCount;
      repeat (200) @(negedge clk8M);
      checkOutput("t5_no_pulse_after_reset", riseCount - r0, 0);
      checkOutput("t5_busy_after_reset", int'(busy), 0);

      $display("[TB] write after reset");
      r0 = riseCount;
      applyStimulus(8'h7E, 1'b1);
      endWrites();
      waitIdle(doneCyc);
      checkOutput("t6_pulses", riseCount - r0, 1);
      checkOutput("t6_sndno", int'(sndno), 8'h7E);
      checkOutput("scoreboard_empty", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/segasys1_sndcmd_tx.md
# segasys1_sndcmd_tx

Main-CPU-side sound command transmitter: accepts 8-bit command writes from the main Z80 port decode, buffers them, and drives the `sndno`/`sndstart` pair consumed by the sound board's play-request latch. Each command is presented as a rising edge on `sndstart` with `sndno` stable, held and spaced so that every command produces exactly one latch/NMI on the sound side. Sits in the main-board top level, between main-CPU I/O decode and the sound subsystem.

## Interface
- `HOLD_CYC`, default 16: clk8M cycles `sndstart` stays high per command (0 treated as 1).
- `GAP_CYC`, default 64: clk8M cycles `sndstart` stays low after each command before the next (0 treated as 1).
- `FIFO_AW`, default 2: log2 FIFO depth (4 entries); used only when the FIFO is compiled in.

Ports:
- `clk8M`  in  1  system clock; same clock as the sound board's play-request logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_wr`  in  1  one-cycle write strobe from the main-CPU port decode.
- `cmd_data`  in  8  command byte, valid with `cmd_wr`.
- `ovf_clr`  in  1  clears `overflow`.
- `sndno`  out  8  command number to the sound board.
- `sndstart`  out  1  command strobe to the sound board; rising edge marks a new command.
- `busy`  out  1  FSM not in IDLE, or buffer non-empty.
- `full`  out  1  buffer full.
- `overflow`  out  1  sticky flag: a write was dropped.

## Operation
- Buffer: FIFO of 2^FIFO_AW entries; write on `cmd_wr` and not full.
- `cmd_wr` while full:
  - A pop in the same cycle accepts the write.
  - Otherwise the byte is dropped and `overflow` is set.
- `overflow` is cleared by `ovf_clr`. A set and a clear in the same cycle leave it set.
- FSM states: IDLE, HOLD, GAP.
  - IDLE: when the buffer is non-empty, pop the head, load it into `sndno`, set `sndstart`=1, load the counter with HOLD_CYC-1, go to HOLD.
  - HOLD: count down. At 0, set `sndstart`=0, load GAP_CYC-1, go to GAP.
  - GAP: count down. At 0, go to IDLE.
- `sndno` keeps the last command after `sndstart` falls, and changes only on an IDLE→HOLD transition.
- Each command gets a fresh rising edge on `sndstart`, including a repeat of the same value.
- Reset mid-operation: the FIFO is emptied, any in-flight command is abandoned, and `sndstart` drops immediately (asynchronously).
- Reset values: `sndno`=0, `sndstart`=0, `busy`=0, `full`=0, `overflow`=0, FSM in IDLE, counter 0.
- Counters are sized for max(HOLD_CYC, GAP_CYC). Both are compile-time constants, so there is no wrap-around.

## Timing
- All outputs are registered.
- `cmd_wr` at edge N with an empty buffer and FSM in IDLE:
  - The entry is visible at N+1.
  - `sndno`/`sndstart`=1 update at edge N+2: 2-cycle latency.
- `sndstart` is high for exactly HOLD_CYC cycles, then low for GAP_CYC cycles.
- The earliest next rising edge is HOLD_CYC+GAP_CYC+1 cycles after the previous one.
- `busy` rises at N+1 and falls on the edge the FSM re-enters IDLE with the buffer empty.
- `full` and `overflow` update on the edge after the causing event.

## Configuration
- `SNDCMD_FIFO_EN` defined: FIFO of 2^FIFO_AW entries as above.
- `SNDCMD_FIFO_EN` undefined: a single pending register replaces the FIFO, with `full` equal to pending-valid.
  - The in-flight command lives in `sndno` and does not occupy the pending slot.
  - Latency, FSM and the `overflow` rules are unchanged.
  - FIFO_AW is ignored.

## Structure
- Package `segasys1_snd_pkg`:
  - FSM state enum (IDLE/HOLD/GAP).
  - Default HOLD/GAP constants.
  - Command width constant (8), shared with the sound side.
- One sub-module: `sndcmd_fifo`, a synchronous FIFO with push/pop/full/empty, asynchronous active-low reset and simultaneous push+pop when full.
- The top module instantiates `sndcmd_fifo` only under `SNDCMD_FIFO_EN`.

## Test plan
- Single write 0x25 after reset: `sndno`=0x25 and `sndstart` rising 2 cycles after `cmd_wr`, high for 16 cycles, then low for 64; `busy` falls after the GAP.
- Back-to-back writes 0x01,0x02,0x03 on consecutive cycles: three `sndstart` pulses with `sndno` 0x01,0x02,0x03 in order, rising edges 81 cycles apart, `overflow`=0.
- Six writes in consecutive cycles, FIFO on, depth 4:
  - The first write is popped into HOLD at cycle 2; writes 2–5 fill the FIFO; write 6 is dropped.
  - `overflow`=1; five pulses are emitted.
  - `ovf_clr` returns `overflow` to 0.
- Repeated value 0x10 written twice: two distinct `sndstart` rising edges with `sndno`=0x10; a sound-side edge detector counts 2.
- `reset_n` low during HOLD with 2 entries queued: `sndstart`=0 immediately and the buffer is empty; after release no pulses occur until a new write.
- Macro undefined, writes 0xA0,0xA1,0xA2 on consecutive cycles: 0xA0 in flight, 0xA1 pending, 0xA2 dropped with `overflow`=1; pulses are 0xA0 then 0xA1 only.
